// File: rtl/shift_reg_universal.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, rotate, parallel load,
// clock enable, tap readout and a fill counter that qualifies the serial output.
module shift_reg_universal #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 7,
  localparam int TW   = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ce,
  input  logic [1:0]             i_mode,
  input  logic                   i_dir,
  input  logic [WIDTH-1:0]       i_si,
  input  logic [WIDTH*DEPTH-1:0] i_pi,
  input  logic [TW-1:0]          i_tap_sel,
  output logic [WIDTH-1:0]       o_so,
  output logic [WIDTH*DEPTH-1:0] o_po,
  output logic [WIDTH-1:0]       o_tap_o,
  output logic                   o_so_valid
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_ROT   = 2'b11;

  logic [WIDTH*DEPTH-1:0] r_stages;
  logic [FW-1:0]          r_fill;
  logic                   r_last_dir;

  logic [WIDTH-1:0]       w_feed;
  logic [WIDTH*DEPTH-1:0] w_shifted;
  logic [WIDTH-1:0]       w_tap;

  // Rotate feeds the stage that would be dropped back in place of SI.
  always_comb begin
    if (i_mode == MODE_ROT)
      w_feed = i_dir ? r_stages[WIDTH-1:0] : r_stages[WIDTH*DEPTH-1 -: WIDTH];
    else
      w_feed = i_si;
    if (i_dir)
      w_shifted = {w_feed, r_stages[WIDTH*DEPTH-1:WIDTH]};
    else
      w_shifted = {r_stages[WIDTH*(DEPTH-1)-1:0], w_feed};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stages   <= '0;
      r_fill     <= '0;
      r_last_dir <= 1'b0;
    end else if (i_ce) begin
      case (i_mode)
        MODE_SHIFT: begin
          r_stages <= w_shifted;
          if (i_dir == r_last_dir) begin
            if (r_fill != FILL_MAX) r_fill <= r_fill + FW'(1);
          end else begin
            r_fill     <= FW'(1);
            r_last_dir <= i_dir;
          end
        end
        MODE_LOAD: begin
          r_stages   <= i_pi;
          r_fill     <= FILL_MAX;
          r_last_dir <= i_dir;
        end
        MODE_ROT:  r_stages <= w_shifted;
        MODE_HOLD: r_stages <= r_stages;
        default:   r_stages <= r_stages;
      endcase
    end
  end

  always_comb begin
    w_tap = '0;
    for (int k = 0; k < DEPTH; k++)
      if (i_tap_sel == TW'(k)) w_tap = r_stages[k*WIDTH +: WIDTH];
  end

  // o_so_valid: o_so carries SI/PI data once DEPTH same-direction entries have
  // accumulated and the current DIR matches the direction they were shifted in.
  assign o_so       = i_dir ? r_stages[WIDTH-1:0] : r_stages[WIDTH*DEPTH-1 -: WIDTH];
  assign o_po       = r_stages;
  assign o_tap_o    = w_tap;
  assign o_so_valid = (r_fill == FILL_MAX) && (i_dir == r_last_dir);

endmodule
